pcie_tx_req_mc: RTL and testbench
=================================

Name: pcie_tx_req_mc

Overview:
- Multi-channel successor to the single-channel PCIe TX request engine.
- Accepts host-write DMA commands from P_NUM_CH independent command FIFOs and arbitrates among them round-robin.
- Splits each command into MWr requests limited by max payload size and, optionally, 4 KB address boundaries.
- Issues one DMA-done record per command, tagged with the originating channel; sits between the per-channel DMA command queues and the shared PCIe TX TLP builder.

Parameters:
- P_NUM_CH, 2, number of command channels (1..8)
- P_SLOT_TAG_WIDTH, 10, host command slot tag width
- C_PCIE_ADDR_WIDTH, 48, PCIe byte address width
- P_TAG_WIDTH, 8, MWr tag width
- Derived: CHW = max(1, clog2(P_NUM_CH))

Ports:
- pcie_user_clk  in  1  clock
- pcie_user_rst  in  1  asynchronous, active-high reset
- pcie_max_payload_size  in  2  00=128B, 01=256B, 10=512B, 11=1024B; registered once per cycle
- cmd_valid  in  P_NUM_CH  per-channel command FIFO not empty
- cmd_rd_en  out  P_NUM_CH  one-hot pop, 1-cycle pulse
- cmd_len  in  P_NUM_CH*11  length in dwords (byte bits [12:2])
- cmd_addr  in  P_NUM_CH*(C_PCIE_ADDR_WIDTH-2)  dword address
- cmd_slot_tag  in  P_NUM_CH*P_SLOT_TAG_WIDTH  slot tag
- cmd_flags  in  P_NUM_CH*3  {auto_cpl, type, done_check}
- tx_fifo_empty_n  in  P_NUM_CH  per-channel TX data FIFO has data
- tx_fifo_free_en  out  P_NUM_CH  one-hot, asserted with tx_dma_mwr_req
- tx_fifo_free_len  out  5  ceil(cur_len_bytes/64)
- tx_dma_mwr_req  out  1  request pulse
- tx_dma_mwr_ch  out  CHW  owning channel
- tx_dma_mwr_tag  out  P_TAG_WIDTH  request tag
- tx_dma_mwr_len  out  11  dwords
- tx_dma_mwr_addr  out  C_PCIE_ADDR_WIDTH-2  dword address
- tx_dma_mwr_req_ack  in  1  request accepted
- dma_tx_done_wr_en  out  1  done write pulse
- dma_tx_done_wr_data  out  CHW+P_SLOT_TAG_WIDTH+15  {ch, auto_cpl, type, done_check, 1'b1, slot_tag, orig_len[10:0]}
- dma_tx_done_wr_rdy_n  in  1  done FIFO full when 1

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer 0; tag counter 0. A reset asserted mid-command abandons the command without producing a done record.
- IDLE: if any cmd_valid is set, go to ARB.
- ARB: grant the first valid channel at or after the pointer (wrapping); latch the grant; pulse cmd_rd_en[grant]; capture the command fields; orig_len <= len; advance the pointer to grant+1 mod P_NUM_CH. If the granted channel has since gone invalid, return to IDLE.
- CALC: cur_len = min(rem_len, MPS_dw, dw_to_4k), where MPS_dw = 32 << mps and dw_to_4k = 1024 - addr[11:2]. If rem_len == 0 (zero-length command), go to DONE_WAIT without issuing any MWr.
- CHK_FIFO: wait for tx_fifo_empty_n[grant].
- MWR_REQ: 1-cycle pulse on tx_dma_mwr_req and tx_fifo_free_en[grant]; len, addr, tag and ch are held stable until ack.
- MWR_ACK: wait for tx_dma_mwr_req_ack. On ack: addr += cur_len; rem_len -= cur_len; tag += 1 with wrap.
- After ack: if rem_len != 0, go to CALC; else go to DONE_WAIT.
- DONE_WAIT: hold while dma_tx_done_wr_rdy_n == 1. DONE_WR: 1-cycle dma_tx_done_wr_en, then IDLE.
- Minimum latency from cmd_valid to the first mwr_req is 4 cycles.
- Arithmetic: addr addition wraps modulo 2^(C_PCIE_ADDR_WIDTH-2). len of 1024 dwords with addr 4K-aligned yields ceil(1024/MPS_dw) requests.
- Arbitration happens only between commands; a command is never preempted.
- An ack arriving in MWR_REQ is ignored.
- mps changes take effect at the next CALC.

Optional Feature:
- PCIE_TX_4K_BOUNDARY_EN
- Defined: the dw_to_4k term is included in CALC, so no MWr crosses a 4 KB boundary.
- Undefined: cur_len = min(rem_len, MPS_dw) only; the boundary logic is removed.

Decomposition:
- Package pcie_tx_pkg:
  - state one-hot encodings
  - MPS-to-dword table
  - done-record field offsets
  - flag bit indices
- Sub-module pcie_tx_rr_arb (P_NUM_CH requests, pointer, one-hot grant plus index).

Test Plan:
- mps=00, ch0 len=0x40 dw, addr=0x1000 -> two MWr (0x20 dw each) at addrs 0x1000 and 0x1020; tags 0 and 1; free_len=2 each; one done with orig_len=0x40, ch=0.
- Feature on, mps=11, len=0x100, addr dword 0x3C0 -> MWr 0x40 dw @0x3C0, then 0xC0 dw @0x400.
- ch0 and ch1 both valid continuously, 3 commands each -> grant order 0,1,0,1,0,1.
- len=0 -> no mwr_req; done record issued with orig_len=0.
- dma_tx_done_wr_rdy_n held at 1 for 10 cycles -> done_wr_en fires on the first cycle after release; no new command is popped meanwhile.
- Reset pulsed during MWR_ACK -> all outputs 0 next cycle; tag and pointer reset; a subsequent command starts at tag 0.

Source files
------------

// File: rtl/pcie_tx_pkg.sv
// Shared definitions for the multi-channel PCIe TX request engine:
// state encodings, MPS lookup, done-record layout and command flag bits.
package pcie_tx_pkg;

  // One-hot state encodings for the request FSM.
  typedef enum logic [7:0] {
    S_IDLE      = 8'h01,
    S_ARB       = 8'h02,
    S_CALC      = 8'h04,
    S_CHK_FIFO  = 8'h08,
    S_MWR_REQ   = 8'h10,
    S_MWR_ACK   = 8'h20,
    S_DONE_WAIT = 8'h40,
    S_DONE_WR   = 8'h80
  } state_e;

  // Command length field width in dwords.
  localparam int LEN_W = 11;

  // Command flag bit indices inside {auto_cpl, type, done_check}.
  localparam int FLAG_DONE_CHECK = 0;
  localparam int FLAG_TYPE       = 1;
  localparam int FLAG_AUTO_CPL   = 2;
  localparam int FLAGS_W         = 3;

  // Done record, LSB first: orig_len, slot_tag, valid bit, flags, channel.
  localparam int DONE_LEN_LSB  = 0;
  localparam int DONE_SLOT_LSB = DONE_LEN_LSB + LEN_W;

  function automatic int done_vld_bit(input int slot_w);
    return DONE_SLOT_LSB + slot_w;
  endfunction

  // Max payload size code to dwords: 128B, 256B, 512B, 1024B.
  function automatic logic [LEN_W-1:0] mps_to_dw(input logic [1:0] mps);
    logic [LEN_W-1:0] dw;
    unique case (mps)
      2'b00:   dw = 11'd32;
      2'b01:   dw = 11'd64;
      2'b10:   dw = 11'd128;
      default: dw = 11'd256;
    endcase
    return dw;
  endfunction

endpackage

// File: rtl/pcie_tx_rr_arb.sv
// Round-robin arbiter: grants the first requesting channel at or after
// ptr_i, wrapping. Purely combinational; the caller owns the pointer.
module pcie_tx_rr_arb #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    int k;
    k         = 0;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      k = int'(ptr_i) + off;
      if (k >= N) k = k - N;
      if (req_i[k]) begin
        gnt_oh_o    = '0;
        gnt_oh_o[k] = 1'b1;
        gnt_idx_o   = IW'(k);
        gnt_vld_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie_tx_req_mc.sv
// Multi-channel PCIe TX request engine. Pops host-write DMA commands from
// P_NUM_CH command FIFOs round-robin, splits each into MWr requests capped by
// max payload size, and writes one done record per command.
// Build option PCIE_TX_4K_BOUNDARY_EN: also split at 4 KB address boundaries.
//
// Handshakes: tx_dma_mwr_req is a one-cycle request pulse; ch/tag/len/addr
// stay stable from that pulse until tx_dma_mwr_req_ack is seen in the
// following wait state (an ack during the pulse cycle is ignored).
// dma_tx_done_wr_en pulses for one cycle only when dma_tx_done_wr_rdy_n was
// low in the previous cycle. cmd_rd_en is a one-cycle one-hot pop.
module pcie_tx_req_mc
  import pcie_tx_pkg::*;
#(
  parameter int P_NUM_CH          = 2,
  parameter int P_SLOT_TAG_WIDTH  = 10,
  parameter int C_PCIE_ADDR_WIDTH = 48,
  parameter int P_TAG_WIDTH       = 8,
  localparam int CHW = (P_NUM_CH > 1) ? $clog2(P_NUM_CH) : 1,
  localparam int AW  = C_PCIE_ADDR_WIDTH - 2,
  localparam int DW  = CHW + P_SLOT_TAG_WIDTH + 15
) (
  input  logic                            pcie_user_clk,
  input  logic                            pcie_user_rst,
  input  logic [1:0]                      pcie_max_payload_size,
  input  logic [P_NUM_CH-1:0]             cmd_valid,
  output logic [P_NUM_CH-1:0]             cmd_rd_en,
  input  logic [P_NUM_CH*LEN_W-1:0]       cmd_len,
  input  logic [P_NUM_CH*AW-1:0]          cmd_addr,
  input  logic [P_NUM_CH*P_SLOT_TAG_WIDTH-1:0] cmd_slot_tag,
  input  logic [P_NUM_CH*FLAGS_W-1:0]     cmd_flags,
  input  logic [P_NUM_CH-1:0]             tx_fifo_empty_n,
  output logic [P_NUM_CH-1:0]             tx_fifo_free_en,
  output logic [4:0]                      tx_fifo_free_len,
  output logic                            tx_dma_mwr_req,
  output logic [CHW-1:0]                  tx_dma_mwr_ch,
  output logic [P_TAG_WIDTH-1:0]          tx_dma_mwr_tag,
  output logic [LEN_W-1:0]                tx_dma_mwr_len,
  output logic [AW-1:0]                   tx_dma_mwr_addr,
  input  logic                            tx_dma_mwr_req_ack,
  output logic                            dma_tx_done_wr_en,
  output logic [DW-1:0]                   dma_tx_done_wr_data,
  input  logic                            dma_tx_done_wr_rdy_n,
  output logic [7:0]                      dbg_state
);

  localparam int DONE_VLD_BIT   = done_vld_bit(P_SLOT_TAG_WIDTH);
  localparam int DONE_FLAGS_LSB = DONE_VLD_BIT + 1;
  localparam int DONE_CH_LSB    = DONE_FLAGS_LSB + FLAGS_W;

  state_e                      state_q, state_d;
  logic [1:0]                  mps_q;
  logic [CHW-1:0]              ptr_q, ptr_d;
  logic [CHW-1:0]              grant_q, grant_d;
  logic [LEN_W-1:0]            orig_len_q, orig_len_d;
  logic [LEN_W-1:0]            rem_len_q, rem_len_d;
  logic [LEN_W-1:0]            cur_len_q, cur_len_d;
  logic [4:0]                  free_len_q, free_len_d;
  logic [AW-1:0]               addr_q, addr_d;
  logic [P_SLOT_TAG_WIDTH-1:0] slot_q, slot_d;
  logic [FLAGS_W-1:0]          flags_q, flags_d;
  logic [P_TAG_WIDTH-1:0]      tag_q, tag_d;

  logic [P_NUM_CH-1:0]         arb_oh;
  logic [CHW-1:0]              arb_idx;
  logic                        arb_vld;

  logic [LEN_W-1:0]            sel_len;
  logic [AW-1:0]               sel_addr;
  logic [P_SLOT_TAG_WIDTH-1:0] sel_slot;
  logic [FLAGS_W-1:0]          sel_flags;

  logic [LEN_W-1:0]            mps_dw;
  logic [LEN_W-1:0]            calc_len;
  logic [4:0]                  calc_free;
  logic [DW-1:0]               done_rec;
`ifdef PCIE_TX_4K_BOUNDARY_EN
  logic [LEN_W-1:0]            dw_to_4k;
`endif

  pcie_tx_rr_arb #(
    .N  (P_NUM_CH),
    .IW (CHW)
  ) u_arb (
    .req_i     (cmd_valid),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx),
    .gnt_vld_o (arb_vld)
  );

  assign sel_len   = cmd_len[arb_idx*LEN_W +: LEN_W];
  assign sel_addr  = cmd_addr[arb_idx*AW +: AW];
  assign sel_slot  = cmd_slot_tag[arb_idx*P_SLOT_TAG_WIDTH +: P_SLOT_TAG_WIDTH];
  assign sel_flags = cmd_flags[arb_idx*FLAGS_W +: FLAGS_W];

  // Size of the next MWr: remaining length clipped to MPS (and 4 KB edge).
  always_comb begin
    mps_dw   = mps_to_dw(mps_q);
    calc_len = (rem_len_q < mps_dw) ? rem_len_q : mps_dw;
`ifdef PCIE_TX_4K_BOUNDARY_EN
    dw_to_4k = 11'd1024 - {1'b0, addr_q[9:0]};
    if (dw_to_4k < calc_len) calc_len = dw_to_4k;
`endif
    // 64-byte TX FIFO units = 16 dwords, rounded up.
    calc_free = 5'((calc_len + 11'd15) >> 4);
  end

  // Done record assembled from the latched command fields.
  always_comb begin
    done_rec = '0;
    done_rec[DONE_LEN_LSB +: LEN_W]             = orig_len_q;
    done_rec[DONE_SLOT_LSB +: P_SLOT_TAG_WIDTH] = slot_q;
    done_rec[DONE_VLD_BIT]                      = 1'b1;
    done_rec[DONE_FLAGS_LSB +: FLAGS_W]         = flags_q;
    done_rec[DONE_CH_LSB +: CHW]                = grant_q;
  end

  // Next-state, datapath updates and pulse outputs.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    orig_len_d = orig_len_q;
    rem_len_d  = rem_len_q;
    cur_len_d  = cur_len_q;
    free_len_d = free_len_q;
    addr_d     = addr_q;
    slot_d     = slot_q;
    flags_d    = flags_q;
    tag_d      = tag_q;
    cmd_rd_en         = '0;
    tx_fifo_free_en   = '0;
    tx_dma_mwr_req    = 1'b0;
    dma_tx_done_wr_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|cmd_valid) state_d = S_ARB;
      end
      S_ARB: begin
        if (arb_vld) begin
          cmd_rd_en  = arb_oh;
          grant_d    = arb_idx;
          orig_len_d = sel_len;
          rem_len_d  = sel_len;
          addr_d     = sel_addr;
          slot_d     = sel_slot;
          flags_d    = sel_flags;
          ptr_d      = (arb_idx == CHW'(P_NUM_CH - 1)) ? '0 : arb_idx + 1'b1;
          state_d    = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (rem_len_q == '0) begin
          state_d = S_DONE_WAIT;
        end else begin
          cur_len_d  = calc_len;
          free_len_d = calc_free;
          state_d    = S_CHK_FIFO;
        end
      end
      S_CHK_FIFO: begin
        if (tx_fifo_empty_n[grant_q]) state_d = S_MWR_REQ;
      end
      S_MWR_REQ: begin
        tx_dma_mwr_req           = 1'b1;
        tx_fifo_free_en[grant_q] = 1'b1;
        state_d                  = S_MWR_ACK;
      end
      S_MWR_ACK: begin
        if (tx_dma_mwr_req_ack) begin
          addr_d    = addr_q + AW'(cur_len_q);
          rem_len_d = rem_len_q - cur_len_q;
          tag_d     = tag_q + 1'b1;
          state_d   = (rem_len_q != cur_len_q) ? S_CALC : S_DONE_WAIT;
        end
      end
      S_DONE_WAIT: begin
        if (!dma_tx_done_wr_rdy_n) state_d = S_DONE_WR;
      end
      S_DONE_WR: begin
        dma_tx_done_wr_en = 1'b1;
        state_d           = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sample the payload-size setting once per cycle.
  always_ff @(posedge pcie_user_clk or posedge pcie_user_rst) begin
    if (pcie_user_rst) mps_q <= 2'b00;
    else               mps_q <= pcie_max_payload_size;
  end

  // FSM state and command datapath registers.
  always_ff @(posedge pcie_user_clk or posedge pcie_user_rst) begin
    if (pcie_user_rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      orig_len_q <= '0;
      rem_len_q  <= '0;
      cur_len_q  <= '0;
      free_len_q <= '0;
      addr_q     <= '0;
      slot_q     <= '0;
      flags_q    <= '0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      orig_len_q <= orig_len_d;
      rem_len_q  <= rem_len_d;
      cur_len_q  <= cur_len_d;
      free_len_q <= free_len_d;
      addr_q     <= addr_d;
      slot_q     <= slot_d;
      flags_q    <= flags_d;
      tag_q      <= tag_d;
    end
  end

  assign tx_fifo_free_len    = free_len_q;
  assign tx_dma_mwr_ch       = grant_q;
  assign tx_dma_mwr_tag      = tag_q;
  assign tx_dma_mwr_len      = cur_len_q;
  assign tx_dma_mwr_addr     = addr_q;
  assign dma_tx_done_wr_data = (state_q == S_DONE_WR) ? done_rec : '0;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_pcie_tx_req_mc.sv
// Directed bench for pcie_tx_req_mc (2 channels, default widths).
module tb_pcie_tx_req_mc;
  import pcie_tx_pkg::*;

  localparam int NCH = 2;
  localparam int SW  = 10;
  localparam int AW  = 46;
  localparam int TW  = 8;
  localparam int CHW = 1;
  localparam int DW  = CHW + SW + 15;
  localparam int MW  = CHW + TW + 11 + AW + 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]         mps;
  logic [NCH-1:0]     cmd_valid;
  logic [NCH-1:0]     cmd_rd_en;
  logic [NCH*11-1:0]  cmd_len;
  logic [NCH*AW-1:0]  cmd_addr;
  logic [NCH*SW-1:0]  cmd_slot_tag;
  logic [NCH*3-1:0]   cmd_flags;
  logic [NCH-1:0]     tx_fifo_empty_n;
  logic [NCH-1:0]     tx_fifo_free_en;
  logic [4:0]         tx_fifo_free_len;
  logic               tx_dma_mwr_req;
  logic [CHW-1:0]     tx_dma_mwr_ch;
  logic [TW-1:0]      tx_dma_mwr_tag;
  logic [10:0]        tx_dma_mwr_len;
  logic [AW-1:0]      tx_dma_mwr_addr;
  logic               tx_dma_mwr_req_ack;
  logic               dma_tx_done_wr_en;
  logic [DW-1:0]      dma_tx_done_wr_data;
  logic               dma_tx_done_wr_rdy_n;
  logic [7:0]         dbg_state;

  pcie_tx_req_mc #(
    .P_NUM_CH          (NCH),
    .P_SLOT_TAG_WIDTH  (SW),
    .C_PCIE_ADDR_WIDTH (AW + 2),
    .P_TAG_WIDTH       (TW)
  ) dut (
    .pcie_user_clk         (clk),
    .pcie_user_rst         (rst),
    .pcie_max_payload_size (mps),
    .cmd_valid             (cmd_valid),
    .cmd_rd_en             (cmd_rd_en),
    .cmd_len               (cmd_len),
    .cmd_addr              (cmd_addr),
    .cmd_slot_tag          (cmd_slot_tag),
    .cmd_flags             (cmd_flags),
    .tx_fifo_empty_n       (tx_fifo_empty_n),
    .tx_fifo_free_en       (tx_fifo_free_en),
    .tx_fifo_free_len      (tx_fifo_free_len),
    .tx_dma_mwr_req        (tx_dma_mwr_req),
    .tx_dma_mwr_ch         (tx_dma_mwr_ch),
    .tx_dma_mwr_tag        (tx_dma_mwr_tag),
    .tx_dma_mwr_len        (tx_dma_mwr_len),
    .tx_dma_mwr_addr       (tx_dma_mwr_addr),
    .tx_dma_mwr_req_ack    (tx_dma_mwr_req_ack),
    .dma_tx_done_wr_en     (dma_tx_done_wr_en),
    .dma_tx_done_wr_data   (dma_tx_done_wr_data),
    .dma_tx_done_wr_rdy_n  (dma_tx_done_wr_rdy_n),
    .dbg_state             (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int exp_tag  = 0;
  int pend[NCH];
  logic ack_en;
  logic [MW-1:0] exp_mwr_q[$];
  logic [DW-1:0] exp_done_q[$];
  int            exp_grant_q[$];

  always_comb begin
    for (int c = 0; c < NCH; c++) cmd_valid[c] = (pend[c] != 0);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int ch, input logic [10:0] len, input logic [AW-1:0] addr,
                         input logic [SW-1:0] slot, input logic [2:0] flags);
    cmd_len[ch*11 +: 11]     = len;
    cmd_addr[ch*AW +: AW]    = addr;
    cmd_slot_tag[ch*SW +: SW] = slot;
    cmd_flags[ch*3 +: 3]     = flags;
  endtask

  task automatic push_cmd(input int ch);
    pend[ch] = pend[ch] + 1;
  endtask

  task automatic exp_mwr(input int ch, input logic [10:0] len, input logic [AW-1:0] addr,
                         input logic [4:0] free);
    logic [CHW-1:0] c;
    logic [TW-1:0]  t;
    c = CHW'(ch);
    t = TW'(exp_tag);
    exp_mwr_q.push_back({c, t, len, addr, free});
    exp_tag = exp_tag + 1;
  endtask

  task automatic exp_done(input int ch, input logic [2:0] flags, input logic [SW-1:0] slot,
                          input logic [10:0] len);
    logic [CHW-1:0] c;
    c = CHW'(ch);
    exp_done_q.push_back({c, flags, 1'b1, slot, len});
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check("done_timeout", done_cnt >= target, 1);
  endtask

  task automatic wait_state(input logic [7:0] s, input int budget);
    int n;
    n = 0;
    while (dbg_state !== s && n < budget) begin
      tick();
      n++;
    end
    check("state_timeout", dbg_state, s);
  endtask

  // Command FIFO model: drop one pending command per observed pop.
  initial forever begin
    logic [NCH-1:0] rd;
    @(negedge clk);
    rd = cmd_rd_en;
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) if (rd[c] && pend[c] > 0) pend[c] = pend[c] - 1;
  end

  // TLP builder model: ack each request one cycle after the pulse.
  initial forever begin
    @(negedge clk);
    if (tx_dma_mwr_req && ack_en) begin
      @(posedge clk);
      #1 tx_dma_mwr_req_ack = 1'b1;
      @(posedge clk);
      #1 tx_dma_mwr_req_ack = 1'b0;
    end
  end

  // Output monitor: grants, MWr requests and done records against queues.
  initial forever begin
    logic [MW-1:0] e;
    @(negedge clk);
    if (cmd_rd_en != '0) begin
      check("grant_expected", exp_grant_q.size() != 0, 1);
      if (exp_grant_q.size() != 0) check("grant", cmd_rd_en, 1 << exp_grant_q.pop_front());
    end
    if (tx_dma_mwr_req) begin
      check("mwr_expected", exp_mwr_q.size() != 0, 1);
      if (exp_mwr_q.size() != 0) begin
        e = exp_mwr_q.pop_front();
        check("mwr_rec", {tx_dma_mwr_ch, tx_dma_mwr_tag, tx_dma_mwr_len, tx_dma_mwr_addr,
                          tx_fifo_free_len}, e);
        check("free_en", tx_fifo_free_en, 1 << e[MW-1 -: CHW]);
      end
    end
    if (dma_tx_done_wr_en) begin
      done_cnt++;
      check("done_expected", exp_done_q.size() != 0, 1);
      if (exp_done_q.size() != 0) check("done_rec", dma_tx_done_wr_data, exp_done_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    mps = 2'b00;
    cmd_len = '0;
    cmd_addr = '0;
    cmd_slot_tag = '0;
    cmd_flags = '0;
    tx_fifo_empty_n = '1;
    tx_dma_mwr_req_ack = 1'b0;
    dma_tx_done_wr_rdy_n = 1'b0;
    ack_en = 1'b1;
    for (int c = 0; c < NCH; c++) pend[c] = 0;
    repeat (3) tick();
    check("rst_state", dbg_state, S_IDLE);
    check("rst_rd_en", cmd_rd_en, 0);
    check("rst_mwr_req", tx_dma_mwr_req, 0);
    check("rst_free_en", tx_fifo_free_en, 0);
    check("rst_done_en", dma_tx_done_wr_en, 0);
    check("rst_done_data", dma_tx_done_wr_data, 0);
    check("rst_mwr_fields", {tx_dma_mwr_ch, tx_dma_mwr_tag, tx_dma_mwr_len, tx_dma_mwr_addr,
                             tx_fifo_free_len}, 0);
    rst = 1'b0;
    tick();

    // T1: mps 128B, 0x40 dw at 0x1000 -> two 0x20 dw MWr, 4-cycle latency.
    set_cmd(0, 11'h040, 46'h1000, 10'h155, 3'b101);
    exp_grant_q.push_back(0);
    exp_mwr(0, 11'h020, 46'h1000, 5'd2);
    exp_mwr(0, 11'h020, 46'h1020, 5'd2);
    exp_done(0, 3'b101, 10'h155, 11'h040);
    push_cmd(0);
    tick(); check("t1_rd_en", cmd_rd_en, 2'b01);
    tick(); check("t1_req_c2", tx_dma_mwr_req, 0);
    tick(); check("t1_req_c3", tx_dma_mwr_req, 0);
    tick(); check("t1_req_c4", tx_dma_mwr_req, 1);
    wait_done(1, 200);
    check("t1_mwr_left", exp_mwr_q.size(), 0);

    // T2: mps 1024B, 0x100 dw at 0x3C0 (splits at 4 KB when enabled).
    mps = 2'b11;
    tick();
    set_cmd(1, 11'h100, 46'h3C0, 10'h2AA, 3'b010);
    exp_grant_q.push_back(1);
`ifdef PCIE_TX_4K_BOUNDARY_EN
    exp_mwr(1, 11'h040, 46'h3C0, 5'd4);
    exp_mwr(1, 11'h0C0, 46'h400, 5'd12);
`else
    exp_mwr(1, 11'h100, 46'h3C0, 5'd16);
`endif
    exp_done(1, 3'b010, 10'h2AA, 11'h100);
    push_cmd(1);
    wait_done(2, 300);
    check("t2_mwr_left", exp_mwr_q.size(), 0);

    // T3: both channels hold 3 commands -> grants 0,1,0,1,0,1.
    mps = 2'b00;
    tick();
    set_cmd(0, 11'h010, 46'h0, 10'h001, 3'b000);
    set_cmd(1, 11'h010, 46'h2000, 10'h002, 3'b001);
    for (int i = 0; i < 3; i++) begin
      exp_grant_q.push_back(0);
      exp_mwr(0, 11'h010, 46'h0, 5'd1);
      exp_done(0, 3'b000, 10'h001, 11'h010);
      exp_grant_q.push_back(1);
      exp_mwr(1, 11'h010, 46'h2000, 5'd1);
      exp_done(1, 3'b001, 10'h002, 11'h010);
    end
    for (int i = 0; i < 3; i++) begin
      push_cmd(0);
      push_cmd(1);
    end
    wait_done(8, 1000);
    check("t3_grant_left", exp_grant_q.size(), 0);
    check("t3_mwr_left", exp_mwr_q.size(), 0);

    // T4: zero-length command -> no MWr, done with orig_len 0.
    set_cmd(0, 11'h000, 46'h55, 10'h3FF, 3'b111);
    exp_grant_q.push_back(0);
    exp_done(0, 3'b111, 10'h3FF, 11'h000);
    push_cmd(0);
    wait_done(9, 100);
    check("t4_done_left", exp_done_q.size(), 0);

    // T5: done FIFO full for 10 cycles; no pop while stalled.
    dma_tx_done_wr_rdy_n = 1'b1;
    set_cmd(1, 11'h020, 46'h100, 10'h0AB, 3'b100);
    exp_grant_q.push_back(1);
    exp_mwr(1, 11'h020, 46'h100, 5'd2);
    exp_done(1, 3'b100, 10'h0AB, 11'h020);
    push_cmd(1);
    wait_state(S_DONE_WAIT, 100);
    set_cmd(0, 11'h008, 46'h0, 10'h005, 3'b000);
    exp_grant_q.push_back(0);
    exp_mwr(0, 11'h008, 46'h0, 5'd1);
    exp_done(0, 3'b000, 10'h005, 11'h008);
    push_cmd(0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5_hold_done", dma_tx_done_wr_en, 0);
      check("t5_hold_pop", cmd_rd_en, 0);
    end
    dma_tx_done_wr_rdy_n = 1'b0;
    tick();
    check("t5_release", dma_tx_done_wr_en, 1);
    wait_done(11, 200);
    check("t5_done_left", exp_done_q.size(), 0);

    // T6: reset while waiting for ack; pointer and tag restart.
    ack_en = 1'b0;
    set_cmd(0, 11'h020, 46'h40, 10'h011, 3'b000);
    exp_grant_q.push_back(0);
    exp_mwr(0, 11'h020, 46'h40, 5'd2);
    push_cmd(0);
    wait_state(S_MWR_ACK, 100);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("t6_state", dbg_state, S_IDLE);
    check("t6_mwr_req", tx_dma_mwr_req, 0);
    check("t6_free_en", tx_fifo_free_en, 0);
    check("t6_mwr_fields", {tx_dma_mwr_ch, tx_dma_mwr_tag, tx_dma_mwr_len, tx_dma_mwr_addr,
                            tx_fifo_free_len}, 0);
    check("t6_done_en", dma_tx_done_wr_en, 0);
    tick();
    rst = 1'b0;
    ack_en = 1'b1;
    exp_tag = 0;
    tick();
    set_cmd(0, 11'h008, 46'h0, 10'h005, 3'b000);
    set_cmd(1, 11'h010, 46'h2000, 10'h002, 3'b001);
    exp_grant_q.push_back(0);
    exp_mwr(0, 11'h008, 46'h0, 5'd1);
    exp_done(0, 3'b000, 10'h005, 11'h008);
    exp_grant_q.push_back(1);
    exp_mwr(1, 11'h010, 46'h2000, 5'd1);
    exp_done(1, 3'b001, 10'h002, 11'h010);
    push_cmd(0);
    push_cmd(1);
    wait_done(13, 300);

    check("end_grant_left", exp_grant_q.size(), 0);
    check("end_mwr_left", exp_mwr_q.size(), 0);
    check("end_done_left", exp_done_q.size(), 0);
    check("end_done_count", done_cnt, 13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
